// File: rtl/cdr_link_pkg.sv
// Shared types and constants for the CDR link: baud NCO defaults, TX frame states
// and the bit-to-level mapping used by the NRZ transmitter.
package cdr_link_pkg;

  localparam int unsigned PHASE_BITS    = 32;
  localparam logic [31:0] FCW_NOM       = 32'h8000_0000;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hF628;

  // s(b): +1 for a one, -1 for a zero
  localparam logic signed [1:0] SymPos = 2'sd1;
  localparam logic signed [1:0] SymNeg = -2'sd1;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSync,
    StPayload,
    StTail
  } tx_state_e;

  function automatic logic signed [9:0] sym_level(logic b, logic signed [9:0] amp);
    logic signed [1:0] s;
    s = b ? SymPos : SymNeg;
    return 10'(s) * amp;
  endfunction

  function automatic logic signed [7:0] sat8(logic signed [9:0] v);
    if (v > 10'sd127) return 8'sd127;
    if (v < -10'sd127) return -8'sd127;
    return v[7:0];
  endfunction

endpackage

// File: rtl/nrz_baud_tx_if.sv
// Byte-wide valid/ready payload channel feeding the NRZ transmitter hold register.
interface nrz_baud_tx_if;

  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_last,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_last,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/tx_baud_nco.sv
// Free-running phase-accumulator NCO; baud_tick strobes on the cycle the accumulator wraps.
module tx_baud_nco #(
  parameter int unsigned           PHASE_BITS = cdr_link_pkg::PHASE_BITS,
  parameter logic [PHASE_BITS-1:0] FCW        = PHASE_BITS'(cdr_link_pkg::FCW_NOM)
) (
  input  logic clk,
  input  logic rst_n,
  output logic baud_tick
);

  logic [PHASE_BITS-1:0] phase_q, phase_d;

  assign phase_d   = phase_q + FCW;
  assign baud_tick = phase_d < phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/nrz_baud_tx.sv
// NRZ frame transmitter: preamble, sync word, handshaked payload and quiet tail,
// emitted one symbol per baud tick with 2-tap de-emphasis on the signed line sample.
module nrz_baud_tx #(
  parameter int unsigned           PHASE_BITS   = cdr_link_pkg::PHASE_BITS,
  parameter logic [PHASE_BITS-1:0] FCW          = PHASE_BITS'(cdr_link_pkg::FCW_NOM),
  parameter int                    AMP          = 64,
  parameter int unsigned           DEEMPH_SHIFT = 2,
  parameter int unsigned           PREAMBLE_LEN = 32,
  parameter logic [15:0]           SYNC_WORD    = cdr_link_pkg::SYNC_WORD_DEF,
  parameter int unsigned           TAIL_LEN     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  nrz_baud_tx_if.slave       tx,
  output logic               baud_tick,
  output logic signed [7:0]  y_n,
  output logic               d_tx,
  output logic               busy,
  output logic               underrun
);

  import cdr_link_pkg::*;

  localparam logic signed [9:0] Main     = 10'(AMP);
  localparam logic signed [9:0] Post     = 10'(AMP >>> DEEMPH_SHIFT);
  localparam logic [15:0]       PreLast  = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0]       TailLast = 16'(TAIL_LEN - 1);

  tx_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        sr_q, sr_d;
  logic              sr_last_q, sr_last_d;
  logic              hold_full_q, hold_full_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic              last_seen_q, last_seen_d;
  logic              underrun_q, underrun_d;
  logic              d_tx_q, d_tx_d;
  logic              prev_act_q, prev_act_d;
  logic signed [7:0] y_q, y_d;
  logic              busy_q, busy_d;

  logic              tx_ready_int;
  logic              xfer;
  logic              sym_act;
  logic              sym_bit;
  logic              handoff;
  logic signed [9:0] post_term;

  tx_baud_nco #(
    .PHASE_BITS (PHASE_BITS),
    .FCW        (FCW)
  ) u_nco (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick)
  );

  assign tx_ready_int = !hold_full_q && !last_seen_q &&
                        (state_q == StPreamble || state_q == StSync || state_q == StPayload);
  assign tx.tx_ready  = tx_ready_int;
  assign xfer         = tx.tx_valid && tx_ready_int;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    sr_last_d   = sr_last_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    last_seen_d = last_seen_q;
    underrun_d  = underrun_q;
    d_tx_d      = d_tx_q;
    prev_act_d  = prev_act_q;
    y_d         = y_q;
    busy_d      = busy_q;
    sym_act     = 1'b0;
    sym_bit     = 1'b0;
    handoff     = 1'b0;
    post_term   = '0;

    // Transfers are not tick-gated; the hold can never be full and accepting at once.
    if (xfer) begin
      hold_full_d = 1'b1;
      hold_data_d = tx.tx_data;
      hold_last_d = tx.tx_last;
      if (tx.tx_last) last_seen_d = 1'b1;
    end

    if (baud_tick) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sym_act     = 1'b1;
            sym_bit     = 1'b1;
            underrun_d  = 1'b0;
            last_seen_d = 1'b0;
            hold_full_d = 1'b0;
            cnt_d       = 16'd1;
            state_d     = StPreamble;
          end
        end
        StPreamble: begin
          sym_act = 1'b1;
          sym_bit = ~cnt_q[0];
          if (cnt_q == PreLast) begin
            cnt_d   = '0;
            state_d = StSync;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StSync: begin
          sym_act = 1'b1;
          sym_bit = SYNC_WORD[~cnt_q[3:0]];
          if (cnt_q[3:0] == 4'd15) handoff = 1'b1;
          else                     cnt_d   = cnt_q + 16'd1;
        end
        StPayload: begin
          sym_act = 1'b1;
          sym_bit = sr_q[7];
          sr_d    = {sr_q[6:0], 1'b0};
          if (cnt_q[2:0] == 3'd7) begin
            if (sr_last_q) begin
              cnt_d   = '0;
              state_d = StTail;
            end else begin
              handoff = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StTail: begin
          if (cnt_q == TailLast) state_d = StIdle;
          else                   cnt_d   = cnt_q + 16'd1;
        end
        default: state_d = StIdle;
      endcase

      if (handoff) begin
        cnt_d = '0;
        if (hold_full_q) begin
          sr_d        = hold_data_q;
          sr_last_d   = hold_last_q;
          hold_full_d = 1'b0;
          state_d     = StPayload;
        end else begin
          underrun_d = 1'b1;
          state_d    = StTail;
        end
      end

      // Post-cursor only follows a driven UI; quiet UIs carry no history.
      if (prev_act_q) post_term = sym_level(d_tx_q, Post);
      y_d        = sym_act ? sat8(sym_level(sym_bit, Main) - post_term) : 8'sd0;
      d_tx_d     = sym_act && sym_bit;
      prev_act_d = sym_act;
      busy_d     = (state_d != StIdle);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      sr_last_q   <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      last_seen_q <= 1'b0;
      underrun_q  <= 1'b0;
      d_tx_q      <= 1'b0;
      prev_act_q  <= 1'b0;
      y_q         <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      sr_last_q   <= sr_last_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      last_seen_q <= last_seen_d;
      underrun_q  <= underrun_d;
      d_tx_q      <= d_tx_d;
      prev_act_q  <= prev_act_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
    end
  end

  assign y_n      = y_q;
  assign d_tx     = d_tx_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_nrz_baud_tx.sv
// Randomized frame-level bench for nrz_baud_tx: expected line levels are built per UI
// from the frame layout and the de-emphasis rule, then compared symbol by symbol.
module tb_nrz_baud_tx;

  localparam int          AMP      = 64;
  localparam int          DSH      = 2;
  localparam int          POST     = AMP >>> DSH;
  localparam int          PRE_LEN  = 32;
  localparam int          TAIL_LEN = 4;
  localparam logic [15:0] SYNC     = 16'hF628;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              baud_tick;
  logic signed [7:0] y_n;
  logic              d_tx;
  logic              busy;
  logic              underrun;

  nrz_baud_tx_if tx_if ();

  nrz_baud_tx #(
    .PHASE_BITS   (32),
    .FCW          (32'h8000_0000),
    .AMP          (AMP),
    .DEEMPH_SHIFT (DSH),
    .PREAMBLE_LEN (PRE_LEN),
    .SYNC_WORD    (SYNC),
    .TAIL_LEN     (TAIL_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx        (tx_if),
    .baud_tick (baud_tick),
    .y_n       (y_n),
    .d_tx      (d_tx),
    .busy      (busy),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] src_q[$];
  logic [7:0] fb[$];
  int         xfer_cnt = 0;
  logic       ready_seen;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int exp_level(input int b, input int prev);
    int v;
    if (b < 0) return 0;
    v = (b != 0) ? AMP : -AMP;
    if (prev >= 0) v = v - ((prev != 0) ? POST : -POST);
    if (v > 127)  v = 127;
    if (v < -127) v = -127;
    return v;
  endfunction

  // Returns 1 ns after the next clock edge on which baud_tick was high.
  task automatic next_ui();
    int n = 0;
    while (!baud_tick && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!baud_tick) check_eq("tick_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Byte source: holds data until a transfer, one transfer per accepted cycle.
  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    tx_if.tx_last  = 1'b0;
    ready_seen     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        src_q.delete();
      end else if (tx_if.tx_valid && ready_seen) begin
        void'(src_q.pop_front());
        xfer_cnt++;
      end
      if (src_q.size() > 0) begin
        tx_if.tx_valid = 1'b1;
        {tx_if.tx_last, tx_if.tx_data} = src_q[0];
      end else begin
        tx_if.tx_valid = 1'b0;
      end
      ready_seen = tx_if.tx_ready;
    end
  end

  task automatic apply_reset(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({nm, "/rst_y"}, int'(y_n), 0);
    check_eq({nm, "/rst_busy"}, int'(busy), 0);
    check_eq({nm, "/rst_dtx"}, int'(d_tx), 0);
    check_eq({nm, "/rst_ready"}, int'(tx_if.tx_ready), 0);
    check_eq({nm, "/rst_ur"}, int'(underrun), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_frame(input string nm, input bit lastf, input int abort_at);
    int         exp_q[$];
    int         prev;
    int         nb;
    int         base;
    bit         exp_ur;
    logic [15:0] sync_v;
    sync_v = SYNC;
    nb     = fb.size();
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back((i % 2 == 0) ? 1 : 0);
    for (int i = 15; i >= 0; i--) exp_q.push_back(int'(sync_v[i]));
    for (int k = 0; k < nb; k++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(int'(fb[k][i]));
      src_q.push_back({lastf && (k == nb - 1), fb[k]});
    end
    exp_ur = !(nb > 0 && lastf);
    base   = xfer_cnt;
    @(negedge clk);
    start = 1'b1;
    prev  = -1;
    foreach (exp_q[i]) begin
      next_ui();
      if (i == 0) begin
        start = 1'b0;
        check_eq({nm, "/ready_first"}, int'(tx_if.tx_ready), 1);
        check_eq({nm, "/ur_cleared"}, int'(underrun), 0);
      end
      check_eq($sformatf("%s/y%0d", nm, i), int'(y_n), exp_level(exp_q[i], prev));
      check_eq($sformatf("%s/d%0d", nm, i), int'(d_tx), exp_q[i]);
      check_eq($sformatf("%s/busy%0d", nm, i), int'(busy), 1);
      prev = exp_q[i];
      if (i == abort_at) begin
        apply_reset(nm);
        fb.delete();
        return;
      end
    end
    for (int j = 1; j <= TAIL_LEN; j++) begin
      next_ui();
      check_eq($sformatf("%s/tail_y%0d", nm, j), int'(y_n), 0);
      check_eq($sformatf("%s/tail_busy%0d", nm, j), int'(busy), (j < TAIL_LEN) ? 1 : 0);
    end
    check_eq({nm, "/underrun"}, int'(underrun), int'(exp_ur));
    check_eq({nm, "/xfers"}, xfer_cnt - base, nb);
    check_eq({nm, "/src_left"}, src_q.size(), 0);
    check_eq({nm, "/ready_idle"}, int'(tx_if.tx_ready), 0);
    repeat (2) next_ui();
    check_eq({nm, "/ur_sticky"}, int'(underrun), int'(exp_ur));
    check_eq({nm, "/idle_y"}, int'(y_n), 0);
    check_eq({nm, "/idle_busy"}, int'(busy), 0);
    fb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_y", int'(y_n), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_ready", int'(tx_if.tx_ready), 0);
    check_eq("reset_dtx", int'(d_tx), 0);
    check_eq("reset_ur", int'(underrun), 0);
    check_eq("reset_tick", int'(baud_tick), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("tick%0d", k), int'(baud_tick), k % 2);
      check_eq($sformatf("idle_y%0d", k), int'(y_n), 0);
      check_eq($sformatf("idle_busy%0d", k), int'(busy), 0);
      check_eq($sformatf("idle_ready%0d", k), int'(tx_if.tx_ready), 0);
    end

    fb.push_back(8'hA5);
    run_frame("a5", 1'b1, -1);

    run_frame("starve", 1'b0, -1);

    fb.push_back(8'h00);
    fb.push_back(8'hFF);
    fb.push_back(8'h00);
    run_frame("stream", 1'b1, -1);

    for (int r = 0; r < 4; r++) begin
      int nb;
      nb = int'($urandom_range(0, 4));
      for (int k = 0; k < nb; k++) fb.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", r), 1'($urandom), -1);
    end

    for (int k = 0; k < 3; k++) fb.push_back(8'($urandom));
    run_frame("abort", 1'b1, PRE_LEN + 16 + 5);

    fb.push_back(8'($urandom));
    fb.push_back(8'($urandom));
    run_frame("after_rst", 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
